// File: rtl/addsub_chunked_pkg.sv
// addsub_chunked_pkg
//   Shared definitions for the chunked adder/subtractor:
//   - state_e  : controller states (IDLE / RUN / DONE), 2-bit encoding
//   - idx_width: width of the chunk index counter, clog2(nch) but never 0
package addsub_chunked_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/addsub_chunked_add_chunk.sv
// add_chunk
//   Combinational W-bit ripple adder made of W full-adder cells.
//   Ports:
//     x, y  [W-1:0] in   addends
//     cin           in   carry in
//     s     [W-1:0] out  sum bits
//     cout          out  carry out of the top cell
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // Full-adder cell per bit: sum = x^y^c, carry = generate | (propagate & c).
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/addsub_chunked.sv
// addsub_chunked
//   Multi-cycle N-bit adder/subtractor. Operands are captured on an accepted
//   start and summed W bits per clock through one shared add_chunk, with the
//   inter-chunk carry held in a register. Subtraction is a + ~b + 1.
//
//   Handshake: start is sampled only while ready=1 (IDLE). The accept edge
//   moves to RUN; NCH edges later the result is loaded into sum/ovf and the
//   block sits one cycle in DONE with done=1, then returns to IDLE. start
//   while ready=0 is dropped, not queued.
//
//   Ports:
//     clk            in   clock, rising edge
//     rst            in   asynchronous active-high reset
//     start          in   request, sampled when ready=1
//     sub            in   0: a+b, 1: a-b (captured with operands)
//     a, b   [N-1:0] in   operands
//     ready          out  high only in IDLE
//     done           out  one-cycle pulse, sum/ovf valid
//     sum    [N:0]   out  registered result, sum[N] = carry out
//     ovf            out  two's complement overflow of sum[N-1:0]
module addsub_chunked
  import addsub_chunked_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N:0]   sum,
  output logic         ovf
);

  localparam int NCH = N / W;
  localparam int IW  = idx_width(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
    $error("addsub_chunked: W must satisfy 1 <= W <= N and divide N");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q,     a_d;
  logic [N-1:0]  b_q,     b_d;
  logic [N-1:0]  acc_q,   acc_d;
  logic [N:0]    sum_q,   sum_d;
  logic          ovf_q,   ovf_d;

  logic [W-1:0]  ch_x, ch_y, ch_s;
  logic          ch_cout;

  // b_q already holds ~b for subtraction, so the chunk adder only ever adds.
  assign ch_x = a_q[idx_q * W +: W];
  assign ch_y = b_q[idx_q * W +: W];

  add_chunk #(.W(W)) u_add_chunk (
    .x    (ch_x),
    .y    (ch_y),
    .cin  (carry_q),
    .s    (ch_s),
    .cout (ch_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;          // the +1 of two's complement negation
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d[idx_q * W +: W] = ch_s;
        carry_d               = ch_cout;
        idx_d                 = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // sum/ovf only change here, so they never expose partial results.
          sum_d   = {ch_cout, acc_d};
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (acc_d[N-1] != a_q[N-1]);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked
//   Three instances share clock, reset and operand inputs: W=4 (main),
//   W=16 and W=1, each with its own start. Expected results come from a
//   plain-arithmetic model (unsigned add/sub, signed range test for ovf).
module tb_addsub_chunked;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sub_r = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          start0 = 1'b0, start16 = 1'b0, start1 = 1'b0;
  logic          ready0, ready16, ready1;
  logic          done0, done16, done1;
  logic [N:0]    sum0, sum16, sum1;
  logic          ovf0, ovf16, ovf1;

  int errors = 0;
  int checks = 0;
  logic [N+1:0] exp_q[$];   // {ovf, sum}

  always #5 clk = ~clk;

  addsub_chunked #(.N(N), .W(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start0), .sub(sub_r), .a(a), .b(b),
    .ready(ready0), .done(done0), .sum(sum0), .ovf(ovf0));

  addsub_chunked #(.N(N), .W(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub_r), .a(a), .b(b),
    .ready(ready16), .done(done16), .sum(sum16), .ovf(ovf16));

  addsub_chunked #(.N(N), .W(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub_r), .a(a), .b(b),
    .ready(ready1), .done(done1), .sum(sum1), .ovf(ovf1));

  // ---------------- reference model ----------------
  function automatic logic [N+1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic sv);
    logic [N:0] s;
    int sa, sb, sr;
    if (!sv) begin
      s = {1'b0, av} + {1'b0, bv};
    end else begin
      s[N-1:0] = av - bv;
      s[N]     = (av >= bv);
    end
    sa = int'($signed(av));
    sb = int'($signed(bv));
    sr = sv ? (sa - sb) : (sa + sb);
    return {((sr > 32767) || (sr < -32768)), s};
  endfunction

  // ---------------- per-instance accessors ----------------
  function automatic logic get_ready(input int sel);
    case (sel)
      0: return ready0;
      1: return ready16;
      default: return ready1;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0: return done0;
      1: return done16;
      default: return done1;
    endcase
  endfunction

  function automatic logic [N:0] get_sum(input int sel);
    case (sel)
      0: return sum0;
      1: return sum16;
      default: return sum1;
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0: return ovf0;
      1: return ovf16;
      default: return ovf1;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start0 = v;
      1: start16 = v;
      default: start1 = v;
    endcase
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input int sel, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic sv, input int exp_lat, output logic [N:0] obs_sum,
                        output logic obs_ovf);
    logic [N+1:0] expv;
    int lat;
    @(negedge clk);
    a = av; b = bv; sub_r = sv;
    set_start(sel, 1'b1);
    exp_q.push_back(model(av, bv, sv));
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    check($sformatf("ready_drop[%0d]", sel), 32'(get_ready(sel)), 32'd0);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      // operands may change freely after capture
      a = N'($urandom); b = N'($urandom); sub_r = 1'($urandom);
      if (get_done(sel)) begin
        lat = c - 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    // lat counts edges after the accept edge at which done was observed
    if (lat < 0) lat = 0;
    expv = exp_q.pop_front();
    obs_sum = get_sum(sel);
    obs_ovf = get_ovf(sel);
    check($sformatf("latency[%0d]", sel), 32'(lat), 32'(exp_lat));
    check($sformatf("sum[%0d]", sel), 32'(obs_sum), 32'(expv[N:0]));
    check($sformatf("ovf[%0d]", sel), 32'(obs_ovf), 32'(expv[N+1]));
    @(posedge clk);
    #1;
    check($sformatf("done_pulse[%0d]", sel), 32'(get_done(sel)), 32'd0);
    check($sformatf("ready_back[%0d]", sel), 32'(get_ready(sel)), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N:0]   s_obs;
    logic         o_obs;
    logic [N+1:0] expv;
    logic [N:0]   held_sum;
    int           ndone;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_sum", 32'(sum0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed, W=4: latency 4
    run_op(0, 16'h1234, 16'h4321, 1'b0, 4, s_obs, o_obs);
    check("dir_add1", 32'({o_obs, s_obs}), 32'({1'b0, 17'h05555}));
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 4, s_obs, o_obs);
    check("dir_ripple", 32'({o_obs, s_obs}), 32'({1'b0, 17'h10000}));
    run_op(0, 16'h0005, 16'h0007, 1'b1, 4, s_obs, o_obs);
    check("dir_sub_borrow", 32'({o_obs, s_obs}), 32'({1'b0, 17'h0FFFE}));
    run_op(0, 16'h8000, 16'h0001, 1'b1, 4, s_obs, o_obs);
    check("dir_sub_ovf", 32'({o_obs, s_obs}), 32'({1'b1, 17'h17FFF}));
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 4, s_obs, o_obs);
    check("dir_add_ovf", 32'({o_obs, s_obs}), 32'({1'b1, 17'h08000}));

    // start held high through RUN with operands changing every cycle
    @(negedge clk);
    a = 16'h0F0F; b = 16'h1111; sub_r = 1'b0; start0 = 1'b1;
    expv = model(16'h0F0F, 16'h1111, 1'b0);
    ndone = 0;
    held_sum = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        ndone++;
        held_sum = sum0;
      end
      @(negedge clk);
      a = N'($urandom); b = N'($urandom); sub_r = 1'($urandom);
      if (ndone != 0) start0 = 1'b0;
    end
    check("held_start_ndone", 32'(ndone), 32'd1);
    check("held_start_sum", 32'(held_sum), 32'(expv[N:0]));
    check("held_start_sum_stays", 32'(sum0), 32'(expv[N:0]));

    // asynchronous reset in the middle of RUN (idx=2)
    @(negedge clk);
    a = 16'h3000; b = 16'h0123; sub_r = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready0), 32'd1);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_sum", 32'(sum0), 32'd0);
    check("mid_rst_ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (done0) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    run_op(0, 16'h0003, 16'h0004, 1'b0, 4, s_obs, o_obs);
    check("after_rst_add", 32'(s_obs), 32'h00007);

    // W=16 (latency 1) and W=1 (latency 16) on the directed vectors
    run_op(1, 16'h1234, 16'h4321, 1'b0, 1, s_obs, o_obs);
    check("w16_add1", 32'(s_obs), 32'h05555);
    run_op(1, 16'h8000, 16'h0001, 1'b1, 1, s_obs, o_obs);
    check("w16_sub_ovf", 32'({o_obs, s_obs}), 32'({1'b1, 17'h17FFF}));
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 16, s_obs, o_obs);
    check("w1_ripple", 32'(s_obs), 32'h10000);
    run_op(2, 16'h0005, 16'h0007, 1'b1, 16, s_obs, o_obs);
    check("w1_sub_borrow", 32'(s_obs), 32'h0FFFE);

    // randomized operations on every instance
    for (int i = 0; i < 12; i++) begin
      run_op(0, N'($urandom), N'($urandom), 1'($urandom), 4, s_obs, o_obs);
      run_op(1, N'($urandom), N'($urandom), 1'($urandom), 1, s_obs, o_obs);
      run_op(2, N'($urandom), N'($urandom), 1'($urandom), 16, s_obs, o_obs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
